// File: rtl/fu_dispatch_scheduler_if.sv
// Interface between the dispatch scheduler and its RS/FU environment.
// master = scheduler side, slave = reservation stations plus functional units.
interface fu_dispatch_scheduler_if #(
   parameter int NUM_RS = 4,
   parameter int NUM_FU = 2
);
   localparam int RW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
   localparam int FW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [NUM_RS-1:0]    rs_ready;
   logic [4*NUM_RS-1:0]  rs_opcode;
   logic [NUM_FU-1:0]    fu_avail;
   logic [NUM_FU-1:0]    fu_done;
   logic [NUM_RS-1:0]    rs_grant;
   logic [NUM_FU-1:0]    fu_issue;
   logic [RW*NUM_FU-1:0] fu_sel_rs;
   logic                 cdb_valid;
   logic [FW-1:0]        cdb_fu;
   logic [NUM_FU-1:0]    fu_ack;
   logic                 err_opcode;
   logic [NUM_FU-1:0]    err_timeout;
   logic [NUM_FU-1:0]    err_overrun;

   modport master (
      input  rs_ready, rs_opcode, fu_avail, fu_done,
      output rs_grant, fu_issue, fu_sel_rs, cdb_valid, cdb_fu, fu_ack,
             err_opcode, err_timeout, err_overrun
   );

   modport slave (
      output rs_ready, rs_opcode, fu_avail, fu_done,
      input  rs_grant, fu_issue, fu_sel_rs, cdb_valid, cdb_fu, fu_ack,
             err_opcode, err_timeout, err_overrun
   );
endinterface

// File: rtl/fu_dispatch_scheduler.sv
// Tomasulo issue/writeback scheduler: round-robin dispatch of ready RS entries
// onto free FUs, per-FU occupancy tracking, and round-robin CDB arbitration.
module fu_dispatch_scheduler #(
   parameter int NUM_RS  = 4,
   parameter int NUM_FU  = 2,
   parameter int TIMEOUT = 16
) (
   input  logic                    clock,
   input  logic                    resetn,
   fu_dispatch_scheduler_if.master bus_io
);
   localparam int RW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
   localparam int FW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_BUSY     = 2'd1,
      ST_WAIT_CDB = 2'd2
   } fu_state_e;

   fu_state_e            state_q [NUM_FU];
   fu_state_e            state_d [NUM_FU];
   logic [CW-1:0]        cnt_q   [NUM_FU];
   logic [CW-1:0]        cnt_d   [NUM_FU];
   logic [RW-1:0]        disp_ptr_q, disp_ptr_d;
   logic [FW-1:0]        cdb_ptr_q, cdb_ptr_d;
   logic [NUM_RS-1:0]    rs_grant_q, rs_grant_d;
   logic [NUM_FU-1:0]    fu_issue_q, fu_issue_d;
   logic [RW*NUM_FU-1:0] fu_sel_rs_q, fu_sel_rs_d;
   logic                 cdb_valid_q, cdb_valid_d;
   logic [FW-1:0]        cdb_fu_q, cdb_fu_d;
   logic [NUM_FU-1:0]    fu_ack_q, fu_ack_d;
   logic                 err_opcode_q, err_opcode_d;
   logic [NUM_FU-1:0]    err_timeout_q, err_timeout_d;
   logic [NUM_FU-1:0]    err_overrun_q, err_overrun_d;

   logic [NUM_RS-1:0]    legal_s;
   logic [NUM_RS-1:0]    cand_s;
   logic [NUM_RS-1:0]    taken_s;
   logic                 found_s;
   logic                 cdb_hit_s;
   int                   rs_idx_s;
   int                   fu_idx_s;

   function automatic logic op_legal(input logic [3:0] op);
      logic ok;
      case (op)
         4'b0000, 4'b0001, 4'b0100, 4'b0010, 4'b0011: ok = 1'b1;
         default:                                     ok = 1'b0;
      endcase
      return ok;
   endfunction

   always_comb begin
      legal_s = {NUM_RS{1'b0}};
      for (int i = 0; i < NUM_RS; i++) begin
         legal_s[i] = op_legal(bus_io.rs_opcode[4*i +: 4]);
      end
   end

   // Entries granted last edge are still shown ready by the RS for one cycle.
   assign cand_s       = bus_io.rs_ready & legal_s & ~rs_grant_q;
   assign err_opcode_d = err_opcode_q | (|(bus_io.rs_ready & ~legal_s));

   always_comb begin
      taken_s     = {NUM_RS{1'b0}};
      found_s     = 1'b0;
      rs_idx_s    = 0;
      rs_grant_d  = {NUM_RS{1'b0}};
      fu_issue_d  = {NUM_FU{1'b0}};
      fu_sel_rs_d = {(RW*NUM_FU){1'b0}};
      disp_ptr_d  = disp_ptr_q;
      for (int f = 0; f < NUM_FU; f++) begin
         found_s = 1'b0;
         if (state_q[f] == ST_IDLE && bus_io.fu_avail[f] && !fu_issue_q[f]) begin
            for (int k = 0; k < NUM_RS; k++) begin
               rs_idx_s = (int'(disp_ptr_q) + k) % NUM_RS;
               if (!found_s && cand_s[rs_idx_s] && !taken_s[rs_idx_s]) begin
                  found_s                  = 1'b1;
                  taken_s[rs_idx_s]        = 1'b1;
                  rs_grant_d[rs_idx_s]     = 1'b1;
                  fu_issue_d[f]            = 1'b1;
                  fu_sel_rs_d[f*RW +: RW]  = RW'(rs_idx_s);
                  disp_ptr_d               = RW'((rs_idx_s + 1) % NUM_RS);
               end else begin
                  found_s = found_s;
               end
            end
         end else begin
            found_s = 1'b0;
         end
      end
   end

   always_comb begin
      cdb_hit_s   = 1'b0;
      fu_idx_s    = 0;
      cdb_fu_d    = {FW{1'b0}};
      cdb_ptr_d   = cdb_ptr_q;
      fu_ack_d    = {NUM_FU{1'b0}};
      for (int k = 0; k < NUM_FU; k++) begin
         fu_idx_s = (int'(cdb_ptr_q) + k) % NUM_FU;
         if (!cdb_hit_s && state_q[fu_idx_s] == ST_WAIT_CDB) begin
            cdb_hit_s          = 1'b1;
            cdb_fu_d           = FW'(fu_idx_s);
            cdb_ptr_d          = FW'((fu_idx_s + 1) % NUM_FU);
            fu_ack_d[fu_idx_s] = 1'b1;
         end else begin
            cdb_hit_s = cdb_hit_s;
         end
      end
      cdb_valid_d = cdb_hit_s;
   end

   // Per-FU occupancy: a second fu_done while waiting keeps the older result.
   always_comb begin
      err_timeout_d = err_timeout_q;
      err_overrun_d = err_overrun_q;
      for (int f = 0; f < NUM_FU; f++) begin
         state_d[f] = state_q[f];
         cnt_d[f]   = cnt_q[f];
         case (state_q[f])
            ST_IDLE: begin
               if (fu_issue_d[f]) begin
                  state_d[f] = ST_BUSY;
                  cnt_d[f]   = {CW{1'b0}};
               end else begin
                  state_d[f] = ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (bus_io.fu_done[f]) begin
                  state_d[f] = ST_WAIT_CDB;
               end else if (cnt_q[f] >= CW'(TIMEOUT - 1)) begin
                  state_d[f]       = ST_IDLE;
                  cnt_d[f]         = CW'(TIMEOUT);
                  err_timeout_d[f] = 1'b1;
               end else begin
                  cnt_d[f] = cnt_q[f] + CW'(1);
               end
            end
            ST_WAIT_CDB: begin
               if (bus_io.fu_done[f]) begin
                  err_overrun_d[f] = 1'b1;
               end else begin
                  err_overrun_d[f] = err_overrun_q[f];
               end
               if (fu_ack_d[f]) begin
                  state_d[f] = ST_IDLE;
               end else begin
                  state_d[f] = ST_WAIT_CDB;
               end
            end
            default: begin
               state_d[f] = ST_IDLE;
            end
         endcase
      end
   end

   // All state and outputs update together; reset wins over any in-flight work.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         for (int f = 0; f < NUM_FU; f++) begin
            state_q[f] <= ST_IDLE;
            cnt_q[f]   <= {CW{1'b0}};
         end
         disp_ptr_q    <= {RW{1'b0}};
         cdb_ptr_q     <= {FW{1'b0}};
         rs_grant_q    <= {NUM_RS{1'b0}};
         fu_issue_q    <= {NUM_FU{1'b0}};
         fu_sel_rs_q   <= {(RW*NUM_FU){1'b0}};
         cdb_valid_q   <= 1'b0;
         cdb_fu_q      <= {FW{1'b0}};
         fu_ack_q      <= {NUM_FU{1'b0}};
         err_opcode_q  <= 1'b0;
         err_timeout_q <= {NUM_FU{1'b0}};
         err_overrun_q <= {NUM_FU{1'b0}};
      end else begin
         for (int f = 0; f < NUM_FU; f++) begin
            state_q[f] <= state_d[f];
            cnt_q[f]   <= cnt_d[f];
         end
         disp_ptr_q    <= disp_ptr_d;
         cdb_ptr_q     <= cdb_ptr_d;
         rs_grant_q    <= rs_grant_d;
         fu_issue_q    <= fu_issue_d;
         fu_sel_rs_q   <= fu_sel_rs_d;
         cdb_valid_q   <= cdb_valid_d;
         cdb_fu_q      <= cdb_fu_d;
         fu_ack_q      <= fu_ack_d;
         err_opcode_q  <= err_opcode_d;
         err_timeout_q <= err_timeout_d;
         err_overrun_q <= err_overrun_d;
      end
   end

   assign bus_io.rs_grant    = rs_grant_q;
   assign bus_io.fu_issue    = fu_issue_q;
   assign bus_io.fu_sel_rs   = fu_sel_rs_q;
   assign bus_io.cdb_valid   = cdb_valid_q;
   assign bus_io.cdb_fu      = cdb_fu_q;
   assign bus_io.fu_ack      = fu_ack_q;
   assign bus_io.err_opcode  = err_opcode_q;
   assign bus_io.err_timeout = err_timeout_q;
   assign bus_io.err_overrun = err_overrun_q;
endmodule

// File: tb/tb_fu_dispatch_scheduler.sv
// Bench for fu_dispatch_scheduler: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_fu_dispatch_scheduler;
   localparam int NUM_RS  = 4;
   localparam int NUM_FU  = 2;
   localparam int TIMEOUT = 16;
   localparam int RW      = 2;
   localparam int FW      = 1;

   logic clock  = 1'b0;
   logic resetn = 1'b0;

   fu_dispatch_scheduler_if #(.NUM_RS(NUM_RS), .NUM_FU(NUM_FU)) bus ();

   fu_dispatch_scheduler #(.NUM_RS(NUM_RS), .NUM_FU(NUM_FU), .TIMEOUT(TIMEOUT)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus_io (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   bit                m_busy [NUM_FU];
   bit                m_pend [NUM_FU];
   int                m_age  [NUM_FU];
   int                m_dptr;
   int                m_cptr;
   logic [NUM_RS-1:0] e_grant;
   logic [NUM_FU-1:0] e_issue, e_ack, e_tout, e_ovr;
   int                e_sel  [NUM_FU];
   bit                e_cvalid;
   int                e_cfu;
   bit                e_errop;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_legal(input logic [3:0] op);
      return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
   endfunction

   task automatic model_step();
      int                q[$];
      logic [NUM_RS-1:0] g;
      logic [NUM_FU-1:0] iss, ack;
      int                sel [NUM_FU];
      bit                cv;
      int                cf;
      int                e;
      g = '0; iss = '0; ack = '0; cv = 1'b0; cf = 0;
      if (!resetn) begin
         for (int f = 0; f < NUM_FU; f++) begin
            m_busy[f] = 1'b0; m_pend[f] = 1'b0; m_age[f] = 0; e_sel[f] = 0;
         end
         m_dptr = 0; m_cptr = 0;
         e_grant = '0; e_issue = '0; e_ack = '0; e_tout = '0; e_ovr = '0;
         e_cvalid = 1'b0; e_cfu = 0; e_errop = 1'b0;
         return;
      end
      for (int k = 0; k < NUM_RS; k++) begin
         int idx;
         idx = (m_dptr + k) % NUM_RS;
         if (bus.rs_ready[idx] && is_legal(bus.rs_opcode[4*idx +: 4]) && !e_grant[idx])
            q.push_back(idx);
      end
      for (int f = 0; f < NUM_FU; f++) begin
         sel[f] = 0;
         if (!m_busy[f] && !m_pend[f] && bus.fu_avail[f] && !e_issue[f] && q.size() > 0) begin
            e = q.pop_front();
            g[e] = 1'b1; iss[f] = 1'b1; sel[f] = e;
            m_dptr = (e + 1) % NUM_RS;
         end
      end
      for (int k = 0; k < NUM_FU; k++) begin
         int j;
         j = (m_cptr + k) % NUM_FU;
         if (!cv && m_pend[j]) begin cv = 1'b1; cf = j; end
      end
      if (cv) begin ack[cf] = 1'b1; m_cptr = (cf + 1) % NUM_FU; end
      for (int f = 0; f < NUM_FU; f++) begin
         if (m_pend[f]) begin
            if (bus.fu_done[f]) e_ovr[f] = 1'b1;
            if (ack[f]) m_pend[f] = 1'b0;
         end else if (m_busy[f]) begin
            if (bus.fu_done[f]) begin
               m_busy[f] = 1'b0; m_pend[f] = 1'b1;
            end else begin
               m_age[f]++;
               if (m_age[f] >= TIMEOUT) begin m_busy[f] = 1'b0; e_tout[f] = 1'b1; end
            end
         end
         if (iss[f]) begin m_busy[f] = 1'b1; m_age[f] = 0; end
      end
      for (int i = 0; i < NUM_RS; i++)
         if (bus.rs_ready[i] && !is_legal(bus.rs_opcode[4*i +: 4])) e_errop = 1'b1;
      e_grant = g; e_issue = iss; e_ack = ack; e_cvalid = cv; e_cfu = cf;
      for (int f = 0; f < NUM_FU; f++) e_sel[f] = sel[f];
   endtask

   task automatic compare_all();
      logic [RW*NUM_FU-1:0] es, msk;
      for (int f = 0; f < NUM_FU; f++) begin
         es[f*RW +: RW]  = RW'(e_sel[f]);
         msk[f*RW +: RW] = {RW{e_issue[f]}};
      end
      check_val("rs_grant",    64'(bus.rs_grant),    64'(e_grant));
      check_val("fu_issue",    64'(bus.fu_issue),    64'(e_issue));
      check_val("fu_sel_rs",   64'(bus.fu_sel_rs & msk), 64'(es & msk));
      check_val("cdb_valid",   64'(bus.cdb_valid),   64'(e_cvalid));
      if (e_cvalid) check_val("cdb_fu", 64'(bus.cdb_fu), 64'(e_cfu));
      check_val("fu_ack",      64'(bus.fu_ack),      64'(e_ack));
      check_val("err_opcode",  64'(bus.err_opcode),  64'(e_errop));
      check_val("err_timeout", 64'(bus.err_timeout), 64'(e_tout));
      check_val("err_overrun", 64'(bus.err_overrun), 64'(e_ovr));
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
   endtask

   logic [3:0] legal_ops [5] = '{4'd0, 4'd1, 4'd4, 4'd2, 4'd3};

   initial begin
      int pct;
      bus.rs_ready  = '0;
      bus.rs_opcode = '0;
      bus.fu_avail  = '0;
      bus.fu_done   = '0;

      // reset held with all entries ready; first grant after release is entry 0
      resetn = 1'b0; bus.rs_ready = 4'hF; bus.fu_avail = 2'b11;
      tick(); tick();
      check_val("t1_rst_grant", 64'(bus.rs_grant), 64'd0);
      check_val("t1_rst_cdb",   64'(bus.cdb_valid), 64'd0);
      resetn = 1'b1;
      tick();
      check_val("t1_first", 64'(bus.rs_grant[0]), 64'd1);

      // two entries onto two free FUs
      do_reset();
      bus.rs_ready = 4'b0011; bus.rs_opcode = 16'h0040; bus.fu_avail = 2'b11;
      tick();
      check_val("t2_grant", 64'(bus.rs_grant), 64'h3);
      check_val("t2_issue", 64'(bus.fu_issue), 64'h3);
      check_val("t2_sel",   64'(bus.fu_sel_rs), 64'h4);

      // simultaneous completion: CDB serves FU0 then FU1
      bus.rs_ready = '0; bus.fu_done = 2'b11;
      tick();
      bus.fu_done = 2'b00;
      tick();
      check_val("t4_cdb0", 64'({bus.cdb_valid, bus.cdb_fu}), 64'h2);
      check_val("t4_ack0", 64'(bus.fu_ack), 64'h1);
      tick();
      check_val("t4_cdb1", 64'({bus.cdb_valid, bus.cdb_fu}), 64'h3);
      check_val("t4_ack1", 64'(bus.fu_ack), 64'h2);

      // timeout on FU0, then it is dispatchable again
      do_reset();
      bus.rs_ready = 4'b0001; bus.fu_avail = 2'b01;
      tick();
      bus.rs_ready = '0;
      for (int i = 0; i < TIMEOUT; i++) tick();
      check_val("t5_timeout", 64'(bus.err_timeout), 64'h1);
      bus.rs_ready = 4'b0001;
      tick();
      check_val("t5_reissue", 64'(bus.fu_issue), 64'h1);

      // overrun on FU1
      do_reset();
      bus.rs_ready = 4'b0011; bus.fu_avail = 2'b11;
      tick();
      bus.rs_ready = '0; bus.fu_done = 2'b10;
      tick(); tick();
      bus.fu_done = '0;
      check_val("t5_overrun", 64'(bus.err_overrun), 64'h2);

      // illegal opcode never granted
      do_reset();
      bus.rs_opcode = 16'h0700; bus.rs_ready = 4'b0100;
      tick(); tick(); tick();
      check_val("t6_nogrant", 64'(bus.rs_grant), 64'h0);
      check_val("t6_errop",   64'(bus.err_opcode), 64'h1);

      // reset while a result is pending discards it
      do_reset();
      bus.rs_opcode = '0; bus.rs_ready = 4'b0001;
      tick();
      bus.rs_ready = '0; bus.fu_done = 2'b01;
      tick();
      bus.fu_done = '0; resetn = 1'b0;
      tick();
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("t6_rst_cdb", 64'(bus.cdb_valid), 64'h0);
      end

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         resetn = ($urandom_range(0, 249) != 0);
         for (int i = 0; i < NUM_RS; i++) begin
            bus.rs_ready[i] = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 19) == 0) bus.rs_opcode[4*i +: 4] = 4'($urandom_range(5, 15));
            else bus.rs_opcode[4*i +: 4] = legal_ops[$urandom_range(0, 4)];
         end
         bus.fu_avail = ($urandom_range(0, 3) == 0) ? NUM_FU'($urandom) : {NUM_FU{1'b1}};
         pct = ((c % 1000) < 600) ? 30 : 3;
         for (int f = 0; f < NUM_FU; f++) bus.fu_done[f] = ($urandom_range(0, 99) < pct);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
